tone_sequencer: RTL and testbench

- Plays a programmable note sequence by driving the maxval input and reset of a downstream clkgen tone divider.
- A small register-file note table holds one (period, duration) pair per entry; period 0 denotes a rest.
- Durations are counted in tempo ticks generated internally from a latched tempo divider.
- Sits between the control/config logic and the tone clkgen in the sound generator.

---
 rtl/tone_sequencer.sv | 156 +++++++++++++++
 tb/tb_tone_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note-table sequencer: steps through (period, duration) entries and drives the
// maxval/reset inputs of a downstream clkgen tone divider, timed by tempo ticks.
module tone_sequencer #(
    parameter int N  = 16,
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [N-1:0]  wr_period_i,
    input  logic [DW-1:0] wr_dur_i,
    input  logic [AW-1:0] len_i,
    input  logic          loop_i,
    input  logic [N-1:0]  tempo_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic [N-1:0]  maxval_o,
    output logic          tone_en_o,
    output logic          gen_reset_o,
    output logic [AW-1:0] idx_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam int DEPTH = 2**AW;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, ADV} state_t;

    logic [N-1:0]  period_mem [DEPTH];
    logic [DW-1:0] dur_mem    [DEPTH];
    logic [N-1:0]  rd_period;
    logic [DW-1:0] rd_dur;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, len_q, len_d;
    logic          loop_q, loop_d;
    logic [N-1:0]  tempo_q, tempo_d, tick_cnt_q, tick_cnt_d;
    logic [DW-1:0] dur_cnt_q, dur_cnt_d;
    logic [N-1:0]  maxval_q, maxval_d;
    logic          tone_en_q, tone_en_d, gen_reset_q, gen_reset_d, done_q, done_d;

    // Table is deliberately not reset so a restart after reset replays it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            period_mem[wr_addr_i] <= wr_period_i;
            dur_mem[wr_addr_i]    <= wr_dur_i;
        end
    end

    assign rd_period = period_mem[idx_q];
    assign rd_dur    = dur_mem[idx_q];

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            tempo_q     <= '0;
            tick_cnt_q  <= '0;
            dur_cnt_q   <= '0;
            maxval_q    <= '0;
            tone_en_q   <= 1'b0;
            gen_reset_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            tempo_q     <= tempo_d;
            tick_cnt_q  <= tick_cnt_d;
            dur_cnt_q   <= dur_cnt_d;
            maxval_q    <= maxval_d;
            tone_en_q   <= tone_en_d;
            gen_reset_q <= gen_reset_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        loop_d      = loop_q;
        tempo_d     = tempo_q;
        tick_cnt_d  = tick_cnt_q;
        dur_cnt_d   = dur_cnt_q;
        maxval_d    = maxval_q;
        tone_en_d   = tone_en_q;
        gen_reset_d = 1'b0;
        done_d      = 1'b0;

        // Abort wins over everything; maxval is left holding the last note.
        if (stop_i && state_q != IDLE) begin
            state_d   = IDLE;
            tone_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        state_d = LOAD;
                        len_d   = len_i;
                        loop_d  = loop_i;
                        tempo_d = tempo_i;
                        idx_d   = '0;
                    end
                end
                LOAD: begin
                    if (rd_dur == '0) begin
                        state_d = ADV;
                    end else begin
                        state_d     = PLAY;
                        maxval_d    = rd_period;
                        tone_en_d   = (rd_period != '0);
                        gen_reset_d = 1'b1;
                        dur_cnt_d   = rd_dur;
                        tick_cnt_d  = '0;
                    end
                end
                PLAY: begin
                    if (tick_cnt_q >= tempo_q) begin
                        tick_cnt_d = '0;
                        dur_cnt_d  = dur_cnt_q - DW'(1);
                        if (dur_cnt_q == DW'(1)) state_d = ADV;
                    end else begin
                        tick_cnt_d = tick_cnt_q + N'(1);
                    end
                end
                ADV: begin
                    if (idx_q != len_q) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = LOAD;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        tone_en_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign maxval_o    = maxval_q;
    assign tone_en_o   = tone_en_q;
    assign gen_reset_o = gen_reset_q;
    assign idx_o       = idx_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_tone_sequencer;
    localparam int N = 16, AW = 4, DW = 8;

    logic          clk_i = 1'b0, reset = 1'b1;
    logic          wr_en_i = 1'b0, loop_i = 1'b0, start_i = 1'b0, stop_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0, len_i = '0;
    logic [N-1:0]  wr_period_i = '0, tempo_i = '0;
    logic [DW-1:0] wr_dur_i = '0;
    logic [N-1:0]  maxval_o;
    logic          tone_en_o, gen_reset_o, busy_o, done_o;
    logic [AW-1:0] idx_o;

    int vectors = 0, miscompares = 0;

    tone_sequencer #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk_i(clk_i), .reset(reset), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_period_i(wr_period_i), .wr_dur_i(wr_dur_i), .len_i(len_i), .loop_i(loop_i),
        .tempo_i(tempo_i), .start_i(start_i), .stop_i(stop_i), .maxval_o(maxval_o),
        .tone_en_o(tone_en_o), .gen_reset_o(gen_reset_o), .idx_o(idx_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic wr(input int a, input int p, input int d);
        wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_period_i = N'(p); wr_dur_i = DW'(d);
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic load_basic();
        wr(0, 10, 2); wr(1, 0, 1); wr(2, 20, 3);
    endtask

    // Returns at sample point s=1 (first cycle in LOAD).
    task automatic start_seq(input int l, input bit lp, input int t);
        len_i = AW'(l); loop_i = lp; tempo_i = N'(t); start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic halt();
        stop_i = 1'b1; step(); stop_i = 1'b0; step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        vectors++;
        if ({idx_o, maxval_o, tone_en_o, gen_reset_o, busy_o, done_o} !== '0) begin
            miscompares++;
            $display("FAIL reset: got idx=%0d maxval=%0d ten=%b gen=%b busy=%b done=%b, want all 0",
                     idx_o, maxval_o, tone_en_o, gen_reset_o, busy_o, done_o);
        end
        reset = 1'b0; step();
    endtask

    task automatic test_basic();
        logic [AW-1:0] ei; logic [N-1:0] em; logic et, eg, eb, ed;
        int gens = 0;
        load_basic();
        start_seq(2, 1'b0, 3);
        for (int s = 1; s <= 32; s++) begin
            ei = '0; em = '0; et = 1'b0;
            if (s >= 2 && s <= 11) begin em = 16'd10; et = 1'b1; end
            if (s >= 11) ei = 4'd1;
            if (s >= 17) ei = 4'd2;
            if (s >= 18) begin em = 16'd20; et = (s <= 30); end
            eg = (s == 2 || s == 12 || s == 18);
            eb = (s <= 30);
            ed = (s == 31);
            vectors++;
            if ({idx_o, maxval_o, tone_en_o, gen_reset_o, busy_o, done_o} !== {ei, em, et, eg, eb, ed}) begin
                miscompares++;
                $display("FAIL basic cyc %0d: got idx=%0d mv=%0d ten=%b gen=%b busy=%b done=%b, want idx=%0d mv=%0d ten=%b gen=%b busy=%b done=%b",
                         s, idx_o, maxval_o, tone_en_o, gen_reset_o, busy_o, done_o, ei, em, et, eg, eb, ed);
            end
            gens += int'(gen_reset_o);
            step();
        end
        vectors++;
        if (gens != 3) begin
            miscompares++;
            $display("FAIL basic gen_reset count: got %0d want 3", gens);
        end
    endtask

    task automatic test_loop_stop();
        logic [AW-1:0] seen [5];
        logic any_done = 1'b0;
        load_basic();
        start_seq(2, 1'b1, 3);
        for (int s = 1; s <= 50; s++) begin
            if (s == 5)  seen[0] = idx_o;
            if (s == 13) seen[1] = idx_o;
            if (s == 20) seen[2] = idx_o;
            if (s == 33) seen[3] = idx_o;
            if (s == 43) seen[4] = idx_o;
            any_done |= done_o;
            if (s < 50) step();
        end
        vectors++;
        if ({seen[0], seen[1], seen[2], seen[3], seen[4]} !== {4'd0, 4'd1, 4'd2, 4'd0, 4'd1}) begin
            miscompares++;
            $display("FAIL loop idx seq: got %0d,%0d,%0d,%0d,%0d want 0,1,2,0,1",
                     seen[0], seen[1], seen[2], seen[3], seen[4]);
        end
        vectors++;
        if ({tone_en_o, maxval_o, any_done} !== {1'b1, 16'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL loop mid-note: got ten=%b mv=%0d done_seen=%b want ten=1 mv=20 done_seen=0",
                     tone_en_o, maxval_o, any_done);
        end
        stop_i = 1'b1; step(); stop_i = 1'b0;
        vectors++;
        if ({busy_o, tone_en_o, gen_reset_o, done_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL stop: got busy=%b ten=%b gen=%b done=%b want 0000",
                     busy_o, tone_en_o, gen_reset_o, done_o);
        end
        step();
        vectors++;
        if ({busy_o, done_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL stop after: got busy=%b done=%b want 00", busy_o, done_o);
        end
    endtask

    task automatic test_skip();
        int gens = 0;
        logic saw99 = 1'b0;
        logic [AW-1:0] idx5 = '0;
        logic [N-1:0]  mv7 = '0;
        logic done12 = 1'b0;
        load_basic();
        wr(1, 99, 0);
        start_seq(2, 1'b0, 0);
        for (int s = 1; s <= 13; s++) begin
            gens += int'(gen_reset_o);
            if (maxval_o == 16'd99) saw99 = 1'b1;
            if (s == 5)  idx5 = idx_o;
            if (s == 7)  mv7 = maxval_o;
            if (s == 12) done12 = done_o;
            step();
        end
        vectors++;
        if (idx5 !== 4'd1) begin
            miscompares++; $display("FAIL skip idx at cyc5: got %0d want 1", idx5);
        end
        vectors++;
        if ({saw99, mv7} !== {1'b0, 16'd10}) begin
            miscompares++; $display("FAIL skip maxval: got saw99=%b mv7=%0d want 0,10", saw99, mv7);
        end
        vectors++;
        if (gens != 2) begin
            miscompares++; $display("FAIL skip gen_reset count: got %0d want 2", gens);
        end
        vectors++;
        if (done12 !== 1'b1) begin
            miscompares++; $display("FAIL skip done timing: got %b want 1", done12);
        end
    endtask

    task automatic test_tempo0();
        wr(0, 5, 1); wr(1, 6, 1);
        start_seq(1, 1'b0, 0);
        step();
        vectors++;
        if ({maxval_o, gen_reset_o} !== {16'd5, 1'b1}) begin
            miscompares++; $display("FAIL t0 note0: got mv=%0d gen=%b want 5,1", maxval_o, gen_reset_o);
        end
        step();
        vectors++;
        if ({maxval_o, gen_reset_o, busy_o} !== {16'd5, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL t0 adv0: got mv=%0d gen=%b busy=%b want 5,0,1", maxval_o, gen_reset_o, busy_o);
        end
        step(); step();
        vectors++;
        if ({maxval_o, gen_reset_o, idx_o} !== {16'd6, 1'b1, 4'd1}) begin
            miscompares++; $display("FAIL t0 note1: got mv=%0d gen=%b idx=%0d want 6,1,1", maxval_o, gen_reset_o, idx_o);
        end
        step();
        vectors++;
        if ({done_o, busy_o} !== 2'b01) begin
            miscompares++; $display("FAIL t0 adv1: got done=%b busy=%b want 0,1", done_o, busy_o);
        end
        step();
        vectors++;
        if ({done_o, busy_o, tone_en_o} !== 3'b100) begin
            miscompares++; $display("FAIL t0 done: got done=%b busy=%b ten=%b want 1,0,0", done_o, busy_o, tone_en_o);
        end
        step();
    endtask

    task automatic test_start_stop();
        logic [AW-1:0] idx11 = '0;
        logic [N-1:0]  mv12 = '1;
        logic d30 = 1'b1, d31 = 1'b0;
        start_i = 1'b1; stop_i = 1'b1; step();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++; $display("FAIL start+stop idle: got busy=%b want 0", busy_o);
        end
        start_i = 1'b0; stop_i = 1'b0; step();
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++; $display("FAIL start+stop idle later: got busy=%b want 0", busy_o);
        end
        load_basic();
        start_seq(2, 1'b0, 3);
        for (int s = 1; s <= 32; s++) begin
            if (s == 11) idx11 = idx_o;
            if (s == 12) mv12 = maxval_o;
            if (s == 30) d30 = done_o;
            if (s == 31) d31 = done_o;
            start_i = (s == 5);
            step();
        end
        start_i = 1'b0;
        vectors++;
        if ({idx11, mv12, d30, d31} !== {4'd1, 16'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL start in play: got idx11=%0d mv12=%0d d30=%b d31=%b want 1,0,0,1", idx11, mv12, d30, d31);
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        start_seq(2, 1'b0, 3);
        for (int s = 1; s < 5; s++) step();
        reset = 1'b1; step();
        vectors++;
        if ({idx_o, maxval_o, tone_en_o, gen_reset_o, busy_o, done_o} !== '0) begin
            miscompares++;
            $display("FAIL reset mid-play: got idx=%0d mv=%0d ten=%b gen=%b busy=%b done=%b want all 0",
                     idx_o, maxval_o, tone_en_o, gen_reset_o, busy_o, done_o);
        end
        reset = 1'b0; step();
        start_seq(2, 1'b0, 3);
        for (int s = 1; s <= 18; s++) begin
            if (s == 2) begin
                vectors++;
                if ({maxval_o, tone_en_o, gen_reset_o} !== {16'd10, 1'b1, 1'b1}) begin
                    miscompares++; $display("FAIL replay note0: got mv=%0d ten=%b gen=%b want 10,1,1", maxval_o, tone_en_o, gen_reset_o);
                end
            end
            if (s == 18) begin
                vectors++;
                if ({maxval_o, gen_reset_o, idx_o} !== {16'd20, 1'b1, 4'd2}) begin
                    miscompares++; $display("FAIL replay note2: got mv=%0d gen=%b idx=%0d want 20,1,2", maxval_o, gen_reset_o, idx_o);
                end
            end
            step();
        end
        halt();
    endtask

    task automatic test_write_play();
        logic [N-1:0] mv9 = '0;
        load_basic();
        start_seq(2, 1'b1, 3);
        for (int s = 1; s <= 32; s++) begin
            if (s == 9) mv9 = maxval_o;
            if (s == 32) begin
                vectors++;
                if ({maxval_o, gen_reset_o, idx_o} !== {16'd30, 1'b1, 4'd0}) begin
                    miscompares++; $display("FAIL write next pass: got mv=%0d gen=%b idx=%0d want 30,1,0", maxval_o, gen_reset_o, idx_o);
                end
            end
            wr_en_i = (s == 4); wr_addr_i = '0; wr_period_i = 16'd30; wr_dur_i = 8'd2;
            step();
        end
        wr_en_i = 1'b0;
        vectors++;
        if (mv9 !== 16'd10) begin
            miscompares++; $display("FAIL write during play: got mv=%0d want 10", mv9);
        end
        halt();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop_stop();
        test_skip();
        test_tempo0();
        test_start_stop();
        test_reset_mid();
        test_write_play();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
